// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RISC-V style datapath: sequences fetch, decode,
// execute, memory and writeback steps and counts retired instructions.
module multicycle_controller #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          instruction_type,
    input  logic                branch_taken,
    input  logic                mem_ready,
    output logic                mem_rd_req,
    output logic                mem_wr_req,
    output logic                adr_src,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_write,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op_mode,
    output logic [1:0]          result_src,
    output logic                illegal,
    output logic [3:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        EXEC_R    = 4'd2,
        EXEC_I    = 4'd3,
        MEM_ADR   = 4'd4,
        MEM_READ  = 4'd5,
        MEM_WB    = 4'd6,
        MEM_WRITE = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JAL       = 4'd10,
        LUI       = 4'd11,
        HALT      = 4'd15
    } state_t;

    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_L = 3'd2;
    localparam logic [2:0] TYPE_S = 3'd3;
    localparam logic [2:0] TYPE_B = 3'd4;
    localparam logic [2:0] TYPE_U = 3'd5;
    localparam logic [2:0] TYPE_J = 3'd6;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
    localparam logic [1:0] SRC_A_RS1    = 2'd2;
    localparam logic [1:0] SRC_A_ZERO   = 2'd3;

    localparam logic [1:0] SRC_B_RS2    = 2'd0;
    localparam logic [1:0] SRC_B_IMM    = 2'd1;
    localparam logic [1:0] SRC_B_FOUR   = 2'd2;

    localparam logic [1:0] OP_ADD       = 2'd0;
    localparam logic [1:0] OP_DECODED   = 2'd1;
    localparam logic [1:0] OP_BRANCH    = 2'd2;

    localparam logic [1:0] RES_ALU_REG  = 2'd0;
    localparam logic [1:0] RES_MEM_DATA = 2'd1;
    localparam logic [1:0] RES_ALU_OUT  = 2'd2;

    state_t cur_state;
    state_t nxt_state;
    logic   retire_now;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Unused encodings 12-14 fall through to HALT via the default arm.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            FETCH: begin
                if (mem_ready) begin
                    nxt_state = DECODE;
                end
            end
            DECODE: begin
                case (instruction_type)
                    TYPE_R:  nxt_state = EXEC_R;
                    TYPE_I:  nxt_state = EXEC_I;
                    TYPE_L:  nxt_state = MEM_ADR;
                    TYPE_S:  nxt_state = MEM_ADR;
                    TYPE_B:  nxt_state = BRANCH;
                    TYPE_U:  nxt_state = LUI;
                    TYPE_J:  nxt_state = JAL;
                    default: nxt_state = HALT;
                endcase
            end
            EXEC_R:  nxt_state = ALU_WB;
            EXEC_I:  nxt_state = ALU_WB;
            MEM_ADR: begin
                if (instruction_type == TYPE_L) begin
                    nxt_state = MEM_READ;
                end else if (instruction_type == TYPE_S) begin
                    nxt_state = MEM_WRITE;
                end else begin
                    nxt_state = HALT;
                end
            end
            MEM_READ: begin
                if (mem_ready) begin
                    nxt_state = MEM_WB;
                end
            end
            MEM_WB:  nxt_state = FETCH;
            MEM_WRITE: begin
                if (mem_ready) begin
                    nxt_state = FETCH;
                end
            end
            ALU_WB:  nxt_state = FETCH;
            BRANCH:  nxt_state = FETCH;
            JAL:     nxt_state = ALU_WB;
            LUI:     nxt_state = ALU_WB;
            HALT:    nxt_state = HALT;
            default: nxt_state = HALT;
        endcase
    end

    // Strobes are forced low whenever reset is held, even before the reset edge.
    always_comb begin
        mem_rd_req  = 1'b0;
        mem_wr_req  = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = SRC_A_PC;
        alu_src_b   = SRC_B_RS2;
        alu_op_mode = OP_ADD;
        result_src  = RES_ALU_REG;
        case (cur_state)
            FETCH: begin
                mem_rd_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_a  = SRC_A_PC;
                    alu_src_b  = SRC_B_FOUR;
                    result_src = RES_ALU_OUT;
                end
            end
            DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
            end
            EXEC_R: begin
                alu_src_a   = SRC_A_RS1;
                alu_src_b   = SRC_B_RS2;
                alu_op_mode = OP_DECODED;
            end
            EXEC_I: begin
                alu_src_a   = SRC_A_RS1;
                alu_src_b   = SRC_B_IMM;
                alu_op_mode = OP_DECODED;
            end
            MEM_ADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            MEM_READ: begin
                mem_rd_req = 1'b1;
                adr_src    = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM_DATA;
            end
            MEM_WRITE: begin
                mem_wr_req = 1'b1;
                adr_src    = 1'b1;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                result_src = RES_ALU_REG;
            end
            BRANCH: begin
                alu_src_a   = SRC_A_RS1;
                alu_src_b   = SRC_B_RS2;
                alu_op_mode = OP_BRANCH;
                pc_write    = branch_taken;
            end
            JAL: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_FOUR;
                pc_write  = 1'b1;
            end
            LUI: begin
                alu_src_a = SRC_A_ZERO;
                alu_src_b = SRC_B_IMM;
            end
            default: ;
        endcase
        if (!rst) begin
            mem_rd_req = 1'b0;
            mem_wr_req = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
        end
    end

    // An instruction retires on the edge that leaves its final step.
    always_comb begin
        retire_now = 1'b0;
        case (cur_state)
            MEM_WB:    retire_now = 1'b1;
            ALU_WB:    retire_now = 1'b1;
            BRANCH:    retire_now = 1'b1;
            MEM_WRITE: retire_now = mem_ready;
            default:   retire_now = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            retired <= '0;
        end else if (retire_now) begin
            retired <= retired + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            illegal <= 1'b0;
        end else if (nxt_state == HALT) begin
            illegal <= 1'b1;
        end
    end

    assign state = cur_state;

endmodule
